mult_issue_pipe: RTL and testbench

//   Issue/retire pipeline wrapped around the combinational 32x32 signed Wallace tree multiplier
//   (WallaceTreeMulti: A, B -> 64-bit Result).
//   - Upstream side: accepts operand pairs over a valid/ready handshake and registers them onto the

---
 rtl/mult_issue_pipe.sv | 92 +++++++++
 tb/tb_mult_issue_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_pipe.sv
// Issue/retire pipeline around a combinational 32x32 signed tree multiplier.
// Operand stage S0 feeds the tree; PIPE_STAGES product registers feed writeback.
module mult_issue_pipe #(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_hi,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [63:0]      mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             busy
);

    typedef struct packed {
        logic             v;
        logic             hi;
        logic [TAG_W-1:0] tag;
        logic [63:0]      p;
    } res_t;

    logic             v0;
    logic             hi0;
    logic [TAG_W-1:0] tag0;
    res_t             st [1:PIPE_STAGES];
    res_t             last;
    logic             advance;
    logic             accept;

    assign last     = st[PIPE_STAGES];
    assign advance  = !last.v || out_ready;
    assign in_ready = advance && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0    <= 1'b0;
            hi0   <= 1'b0;
            tag0  <= '0;
            mul_a <= '0;
            mul_b <= '0;
        end else if (flush) begin
            v0 <= 1'b0;
        end else if (advance) begin
            v0 <= accept;
            if (accept) begin
                hi0   <= in_hi;
                tag0  <= in_tag;
                mul_a <= in_a;
                mul_b <= in_b;
            end
        end
    end

    // Whole-pipe stall: either every stage shifts or none does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= PIPE_STAGES; i++) st[i] <= '0;
        end else if (flush) begin
            for (int i = 1; i <= PIPE_STAGES; i++) st[i].v <= 1'b0;
        end else if (advance) begin
            st[1] <= '{v: v0, hi: hi0, tag: tag0, p: mul_result};
            for (int i = 2; i <= PIPE_STAGES; i++) st[i] <= st[i-1];
        end
    end

    always_comb begin
        busy = v0;
        for (int i = 1; i <= PIPE_STAGES; i++) busy = busy | st[i].v;
    end

    assign out_valid = last.v;
    assign out_tag   = last.tag;
    assign out_data  = last.hi ? last.p[63:32] : last.p[31:0];
    // Flags are qualified by valid so stale data after flush/reset reads as 0.
    assign out_ovf   = last.v && (last.p[63:32] != {32{last.p[31]}});
    assign out_zero  = last.v && (out_data == 32'd0);

endmodule

// File: tb/tb_mult_issue_pipe.sv
// Randomized + directed bench for mult_issue_pipe.
// Scoreboard of expected results computed with plain 64-bit arithmetic.
module tb_mult_issue_pipe;

    localparam int PS = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_hi = 1'b0;
    logic          out_ready = 1'b1;
    logic [31:0]   in_a = '0;
    logic [31:0]   in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          in_ready;
    logic [31:0]   mul_a;
    logic [31:0]   mul_b;
    logic [63:0]   mul_result;
    logic          out_valid;
    logic [31:0]   out_data;
    logic [TW-1:0] out_tag;
    logic          out_ovf;
    logic          out_zero;
    logic          busy;

    mult_issue_pipe #(.PIPE_STAGES(PS), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_hi(in_hi), .in_tag(in_tag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag),
        .out_ovf(out_ovf), .out_zero(out_zero), .busy(busy)
    );

    // Stand-in for the Wallace tree
    assign mul_result = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0]   d;
        logic [TW-1:0] t;
        logic          o;
        logic          z;
    } exp_t;

    exp_t sb[$];
    int   rets[$];
    int   cyc = 0;
    logic pv_stall = 1'b0;
    logic [31:0]   pv_data = '0;
    logic [TW-1:0] pv_tag = '0;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic hi, input logic [TW-1:0] t);
        logic [63:0] sa, sbv, p;
        exp_t e;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        p   = sa * sbv;
        e.d = hi ? p[63:32] : p[31:0];
        e.t = t;
        e.o = (p[63:32] != {32{p[31]}});
        e.z = (e.d == 32'd0);
        return e;
    endfunction

    task automatic step(input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic hi,
                        input logic [TW-1:0] t, input logic ordy,
                        input logic fl, output logic acc);
        logic ret;
        exp_t e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_hi     = hi;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        #1;
        check("in_ready", 64'(in_ready), 64'(!fl && (!out_valid || ordy)));
        check("busy", 64'(busy), 64'(sb.size() != 0));
        if (pv_stall) begin
            check("hold_v", 64'(out_valid), 64'd1);
            check("hold_d", 64'(out_data), 64'(pv_data));
            check("hold_t", 64'(out_tag), 64'(pv_tag));
        end
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious", 64'(out_valid), 64'd0);
            end else begin
                e = sb[0];
                check("data", 64'(out_data), 64'(e.d));
                check("tag", 64'(out_tag), 64'(e.t));
                check("ovf", 64'(out_ovf), 64'(e.o));
                check("zero", 64'(out_zero), 64'(e.z));
            end
        end
        acc      = v && in_ready;
        ret      = out_valid && ordy;
        pv_stall = out_valid && !ordy && !fl;
        pv_data  = out_data;
        pv_tag   = out_tag;
        @(posedge clk);
        if (ret && sb.size() > 0) begin
            void'(sb.pop_front());
            rets.push_back(cyc);
        end
        if (fl) sb.delete();
        else if (acc) sb.push_back(model(a, b, hi, t));
        if (sb.size() > PS + 1) check("cap", 64'(sb.size()), 64'(PS + 1));
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        logic a;
        step(1'b0, 32'd0, 32'd0, 1'b0, '0, ordy, 1'b0, a);
    endtask

    // Accept one op, then confirm it surfaces exactly PS edges later.
    task automatic issue_one(input logic [31:0] a, input logic [31:0] b,
                             input logic hi, input logic [TW-1:0] t);
        logic acc;
        step(1'b1, a, b, hi, t, 1'b1, 1'b0, acc);
        check("issue_acc", 64'(acc), 64'd1);
        for (int i = 0; i < PS; i++) begin
            check("lat_early", 64'(out_valid), 64'd0);
            idle(1'b1);
        end
        check("lat_due", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 20) begin
            idle(1'b1);
            n++;
        end
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_sb", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [31:0] rnd32();
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0: r = 32'($urandom_range(0, 200)) - 32'd100;
            1: r = $urandom;
            2: r = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   n0;
        int   t0;
        int   j;
        int   guard;
        logic [31:0] oa [6];
        logic [31:0] ob [6];

        // Reset state
        #2;
        check("rst_ov", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ma", 64'(mul_a), 64'd0);
        check("rst_mb", 64'(mul_b), 64'd0);
        check("rst_d", 64'(out_data), 64'd0);
        check("rst_t", 64'(out_tag), 64'd0);
        check("rst_o", 64'(out_ovf), 64'd0);
        check("rst_z", 64'(out_zero), 64'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdy", 64'(in_ready), 64'd1);

        // 1: basic latency
        issue_one(32'd5, 32'd5, 1'b0, 4'd3);
        check("t1_d", 64'(out_data), 64'd25);
        check("t1_t", 64'(out_tag), 64'd3);
        check("t1_o", 64'(out_ovf), 64'd0);
        check("t1_z", 64'(out_zero), 64'd0);
        drain();

        // 2: back-to-back
        n0 = rets.size();
        step(1'b1, -32'sd5, -32'sd7, 1'b0, 4'd1, 1'b1, 1'b0, acc);
        step(1'b1, -32'sd5, 32'd7, 1'b0, 4'd2, 1'b1, 1'b0, acc);
        step(1'b1, 32'd1, -32'sd90, 1'b0, 4'd3, 1'b1, 1'b0, acc);
        step(1'b1, 32'd1, -32'sd90, 1'b1, 4'd4, 1'b1, 1'b0, acc);
        drain();
        check("t2_cnt", 64'(rets.size() - n0), 64'd4);
        if (rets.size() - n0 == 4)
            for (int i = 0; i < 3; i++)
                check("t2_b2b", 64'(rets[n0+i+1] - rets[n0+i]), 64'd1);

        // 3: width checks
        issue_one(32'h7FFF_FFFF, 32'd2, 1'b0, 4'd5);
        check("t3a_d", 64'(out_data), 64'hFFFF_FFFE);
        check("t3a_o", 64'(out_ovf), 64'd1);
        issue_one(32'h7FFF_FFFF, 32'd2, 1'b1, 4'd6);
        check("t3b_d", 64'(out_data), 64'd0);
        check("t3b_z", 64'(out_zero), 64'd1);
        check("t3b_o", 64'(out_ovf), 64'd1);
        issue_one(32'd0, -32'sd24, 1'b0, 4'd7);
        check("t3c_z", 64'(out_zero), 64'd1);
        drain();

        // 4: stream with a 5-cycle output stall
        oa[0] = 32'd234; ob[0] = 32'd345;
        oa[1] = 32'd13;  ob[1] = 32'd10;
        for (int i = 2; i < 6; i++) begin
            oa[i] = rnd32();
            ob[i] = rnd32();
        end
        n0 = rets.size();
        t0 = cyc;
        j = 0;
        guard = 0;
        while (j < 6 && guard < 40) begin
            if (cyc == t0 + 6) begin
                check("t4_full", 64'(sb.size()), 64'(PS + 1));
                check("t4_rdy", 64'(in_ready), 64'd0);
            end
            step(1'b1, oa[j], ob[j], 1'b0, 4'(j), !(cyc >= t0 + 2 && cyc < t0 + 7),
                 1'b0, acc);
            if (acc) j++;
            guard++;
        end
        check("t4_issued", 64'(j), 64'd6);
        drain();
        check("t4_cnt", 64'(rets.size() - n0), 64'd6);

        // 5: flush
        step(1'b1, 32'd3, 32'd4, 1'b0, 4'd1, 1'b1, 1'b0, acc);
        step(1'b1, 32'd6, 32'd7, 1'b0, 4'd2, 1'b1, 1'b0, acc);
        step(1'b1, 32'd8, 32'd9, 1'b0, 4'd3, 1'b1, 1'b1, acc);
        check("t5_acc", 64'(acc), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_ov", 64'(out_valid), 64'd0);
        issue_one(32'd13, 32'd10, 1'b0, 4'd9);
        check("t5_d", 64'(out_data), 64'd130);
        drain();

        // 6: async reset mid-flight
        step(1'b1, 32'd11, 32'd12, 1'b0, 4'd1, 1'b1, 1'b0, acc);
        step(1'b1, 32'd21, 32'd22, 1'b0, 4'd2, 1'b1, 1'b0, acc);
        step(1'b1, 32'd31, 32'd32, 1'b0, 4'd3, 1'b1, 1'b0, acc);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("t6_ov", 64'(out_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_d", 64'(out_data), 64'd0);
        #2 rst_n = 1'b1;
        sb.delete();
        pv_stall = 1'b0;
        @(negedge clk);
        issue_one(32'd5, 32'd5, 1'b0, 4'd4);
        check("t6_res", 64'(out_data), 64'd25);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rnd32(), rnd32(),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
